// File: rtl/sys_defs.sv
// Shared bus definitions for the processor/memory interface.
// Command encodings, widths and arbiter defaults.
package sys_defs;

    localparam int XLEN             = 32;
    localparam int TAG_W            = 4;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } bus_command_t;

endpackage

// File: rtl/mem_tag_table.sv
// Owner table for outstanding memory tags 1..15.
// Clear is applied before allocate so a tag can be reused in one cycle.
module mem_tag_table
    import sys_defs::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             alloc_en,
    input  logic [TAG_W-1:0] alloc_tag,
    input  logic             alloc_owner_d,
    input  logic             clear_en,
    input  logic [TAG_W-1:0] clear_tag,
    input  logic [TAG_W-1:0] lookup_tag,
    output logic             lookup_valid,
    output logic             lookup_owner_d
);

    logic [15:1] valid;
    logic [15:1] owner_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            valid   <= '0;
            owner_d <= '0;
        end else begin
            if (clear_en && clear_tag != '0) begin
                valid[clear_tag] <= 1'b0;
            end
            if (alloc_en && alloc_tag != '0) begin
                valid[alloc_tag]   <= 1'b1;
                owner_d[alloc_tag] <= alloc_owner_d;
            end
        end
    end

    always_comb begin
        lookup_valid   = 1'b0;
        lookup_owner_d = 1'b0;
        if (lookup_tag != '0) begin
            lookup_valid   = valid[lookup_tag];
            lookup_owner_d = owner_d[lookup_tag];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the memory bus between dcache and icache, with starvation
// protection for the icache and per-tag routing of returning data.
module mem_arbiter
    import sys_defs::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  bus_command_t     dcache2mem_command,
    input  logic [XLEN-1:0]  dcache2mem_addr,
    input  logic [63:0]      dcache2mem_data,
    input  bus_command_t     icache2mem_command,
    input  logic [XLEN-1:0]  icache2mem_addr,
    input  logic [TAG_W-1:0] mem2proc_response,
    input  logic [63:0]      mem2proc_data,
    input  logic [TAG_W-1:0] mem2proc_tag,
    output bus_command_t     proc2mem_command,
    output logic [XLEN-1:0]  proc2mem_addr,
    output logic [63:0]      proc2mem_data,
    output logic             d_request,
    output logic [TAG_W-1:0] mem2dcache_response,
    output logic [TAG_W-1:0] mem2icache_response,
    output logic [TAG_W-1:0] mem2dcache_tag,
    output logic [TAG_W-1:0] mem2icache_tag,
    output logic [63:0]      mem2dcache_data,
    output logic [63:0]      mem2icache_data,
    output logic             tag_error
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             d_active;
    logic             i_active;
    logic             override;
    logic             d_grant;
    logic             i_grant;
    logic             alloc_en;
    logic             ret_hit;
    logic             lookup_valid;
    logic             lookup_owner_d;

    assign d_active = dcache2mem_command != BUS_NONE;
    assign i_active = icache2mem_command != BUS_NONE;
    assign override = starve_cnt == CNT_W'(STARVE_LIMIT);

    // Reset forces both grants low so the bus stays quiet.
    assign d_grant = !reset && d_active && !override;
    assign i_grant = !reset && !d_grant && i_active;

    assign d_request = d_grant;

    always_comb begin
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        if (d_grant) begin
            proc2mem_command = dcache2mem_command;
            proc2mem_addr    = dcache2mem_addr;
            proc2mem_data    = dcache2mem_data;
        end else if (i_grant) begin
            proc2mem_command = icache2mem_command;
            proc2mem_addr    = icache2mem_addr;
        end
    end

    assign mem2dcache_response = d_grant ? mem2proc_response : '0;
    assign mem2icache_response = i_grant ? mem2proc_response : '0;

    assign mem2dcache_data = mem2proc_data;
    assign mem2icache_data = mem2proc_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (i_grant || !i_active) begin
            starve_cnt <= '0;
        end else if (d_grant) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Only accepted loads produce a return; stores are fire-and-forget.
    assign alloc_en = (proc2mem_command == BUS_LOAD)
                   && (mem2proc_response != '0);

    assign ret_hit = !reset && mem2proc_tag != '0 && lookup_valid;

    assign mem2dcache_tag = (ret_hit && lookup_owner_d)  ? mem2proc_tag : '0;
    assign mem2icache_tag = (ret_hit && !lookup_owner_d) ? mem2proc_tag : '0;

    assign tag_error = !reset && mem2proc_tag != '0 && !lookup_valid;

    mem_tag_table u_tag_table (
        .clock          (clock),
        .reset          (reset),
        .alloc_en       (alloc_en),
        .alloc_tag      (mem2proc_response),
        .alloc_owner_d  (d_grant),
        .clear_en       (ret_hit),
        .clear_tag      (mem2proc_tag),
        .lookup_tag     (mem2proc_tag),
        .lookup_valid   (lookup_valid),
        .lookup_owner_d (lookup_owner_d)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grant, steering, starvation,
// tag ownership, reuse and reset behaviour.
module tb_mem_arbiter;
    import sys_defs::*;

    logic         clock;
    logic         reset;
    bus_command_t dcache2mem_command;
    logic [31:0]  dcache2mem_addr;
    logic [63:0]  dcache2mem_data;
    bus_command_t icache2mem_command;
    logic [31:0]  icache2mem_addr;
    logic [3:0]   mem2proc_response;
    logic [63:0]  mem2proc_data;
    logic [3:0]   mem2proc_tag;
    bus_command_t proc2mem_command;
    logic [31:0]  proc2mem_addr;
    logic [63:0]  proc2mem_data;
    logic         d_request;
    logic [3:0]   mem2dcache_response;
    logic [3:0]   mem2icache_response;
    logic [3:0]   mem2dcache_tag;
    logic [3:0]   mem2icache_tag;
    logic [63:0]  mem2dcache_data;
    logic [63:0]  mem2icache_data;
    logic         tag_error;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clock               (clock),
        .reset               (reset),
        .dcache2mem_command  (dcache2mem_command),
        .dcache2mem_addr     (dcache2mem_addr),
        .dcache2mem_data     (dcache2mem_data),
        .icache2mem_command  (icache2mem_command),
        .icache2mem_addr     (icache2mem_addr),
        .mem2proc_response   (mem2proc_response),
        .mem2proc_data       (mem2proc_data),
        .mem2proc_tag        (mem2proc_tag),
        .proc2mem_command    (proc2mem_command),
        .proc2mem_addr       (proc2mem_addr),
        .proc2mem_data       (proc2mem_data),
        .d_request           (d_request),
        .mem2dcache_response (mem2dcache_response),
        .mem2icache_response (mem2icache_response),
        .mem2dcache_tag      (mem2dcache_tag),
        .mem2icache_tag      (mem2icache_tag),
        .mem2dcache_data     (mem2dcache_data),
        .mem2icache_data     (mem2icache_data),
        .tag_error           (tag_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic idle();
        dcache2mem_command = BUS_NONE;
        dcache2mem_addr    = '0;
        dcache2mem_data    = '0;
        icache2mem_command = BUS_NONE;
        icache2mem_addr    = '0;
        mem2proc_response  = '0;
        mem2proc_data      = '0;
        mem2proc_tag       = '0;
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1 after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        icache2mem_command = BUS_LOAD;
        dcache2mem_command = BUS_LOAD;
        mem2proc_response  = 4'd3;
        mem2proc_tag       = 4'd5;
        step();
        step();
        #1;
        if (proc2mem_command !== BUS_NONE) begin
            $display("FAIL rst_cmd got %0d want 0", proc2mem_command);
            n_fail++;
        end
        n_tests++;
        if (d_request !== 1'b0) begin
            $display("FAIL rst_dreq got %0b want 0", d_request);
            n_fail++;
        end
        n_tests++;
        if (mem2icache_response !== 4'd0 || mem2dcache_response !== 4'd0) begin
            $display("FAIL rst_resp got %0d/%0d want 0/0",
                     mem2dcache_response, mem2icache_response);
            n_fail++;
        end
        n_tests++;
        if (tag_error !== 1'b0 || mem2dcache_tag !== 4'd0
            || mem2icache_tag !== 4'd0) begin
            $display("FAIL rst_tag got err=%0b d=%0d i=%0d want 0",
                     tag_error, mem2dcache_tag, mem2icache_tag);
            n_fail++;
        end
        n_tests++;
        idle();
        reset = 1'b0;
        step();
    endtask

    task automatic test_icache_only();
        idle();
        icache2mem_command = BUS_LOAD;
        icache2mem_addr    = 32'h100;
        mem2proc_response  = 4'd3;
        #1;
        if (mem2icache_response !== 4'd3 || mem2dcache_response !== 4'd0) begin
            $display("FAIL ic_resp got d=%0d i=%0d want d=0 i=3",
                     mem2dcache_response, mem2icache_response);
            n_fail++;
        end
        n_tests++;
        if (d_request !== 1'b0 || proc2mem_command !== BUS_LOAD
            || proc2mem_addr !== 32'h100) begin
            $display("FAIL ic_bus got dreq=%0b cmd=%0d addr=%0h want 0/1/100",
                     d_request, proc2mem_command, proc2mem_addr);
            n_fail++;
        end
        n_tests++;
        step();
        idle();
        step();
        mem2proc_tag  = 4'd3;
        mem2proc_data = 64'h1122_3344_5566_7788;
        #1;
        if (mem2icache_tag !== 4'd3 || mem2dcache_tag !== 4'd0
            || tag_error !== 1'b0) begin
            $display("FAIL ic_tag got d=%0d i=%0d err=%0b want d=0 i=3 err=0",
                     mem2dcache_tag, mem2icache_tag, tag_error);
            n_fail++;
        end
        n_tests++;
        if (mem2icache_data !== 64'h1122_3344_5566_7788
            || mem2dcache_data !== 64'h1122_3344_5566_7788) begin
            $display("FAIL data_pass got %0h/%0h want 1122334455667788",
                     mem2dcache_data, mem2icache_data);
            n_fail++;
        end
        n_tests++;
        step();
        mem2proc_data = '0;
        #1;
        if (tag_error !== 1'b1 || mem2icache_tag !== 4'd0) begin
            $display("FAIL ic_tag_clr got err=%0b i=%0d want err=1 i=0",
                     tag_error, mem2icache_tag);
            n_fail++;
        end
        n_tests++;
        step();
        idle();
        step();
    endtask

    task automatic test_contention();
        idle();
        dcache2mem_command = BUS_LOAD;
        dcache2mem_addr    = 32'h200;
        icache2mem_command = BUS_LOAD;
        icache2mem_addr    = 32'h300;
        mem2proc_response  = 4'd5;
        #1;
        if (d_request !== 1'b1 || proc2mem_addr !== 32'h200) begin
            $display("FAIL ct_grant got dreq=%0b addr=%0h want 1/200",
                     d_request, proc2mem_addr);
            n_fail++;
        end
        n_tests++;
        if (mem2dcache_response !== 4'd5 || mem2icache_response !== 4'd0) begin
            $display("FAIL ct_resp got d=%0d i=%0d want d=5 i=0",
                     mem2dcache_response, mem2icache_response);
            n_fail++;
        end
        n_tests++;
        step();
        idle();
        step();
        mem2proc_tag = 4'd5;
        #1;
        if (mem2dcache_tag !== 4'd5 || mem2icache_tag !== 4'd0) begin
            $display("FAIL ct_tag got d=%0d i=%0d want d=5 i=0",
                     mem2dcache_tag, mem2icache_tag);
            n_fail++;
        end
        n_tests++;
        step();
        idle();
        step();
    endtask

    task automatic test_starvation();
        logic exp_d;
        idle();
        dcache2mem_command = BUS_LOAD;
        dcache2mem_addr    = 32'h400;
        icache2mem_command = BUS_LOAD;
        icache2mem_addr    = 32'h500;
        for (int i = 0; i < 10; i++) begin
            #1;
            exp_d = !(i == 4 || i == 9);
            if (d_request !== exp_d) begin
                $display("FAIL starve_c%0d got dreq=%0b want %0b",
                         i, d_request, exp_d);
                n_fail++;
            end
            n_tests++;
            if (i == 4 && proc2mem_addr !== 32'h500) begin
                $display("FAIL starve_addr got %0h want 500", proc2mem_addr);
                n_fail++;
            end
            if (i == 4) n_tests++;
            step();
        end
        idle();
        step();
    endtask

    task automatic test_store();
        idle();
        dcache2mem_command = BUS_STORE;
        dcache2mem_addr    = 32'h600;
        dcache2mem_data    = 64'hDEAD_BEEF_CAFE_F00D;
        mem2proc_response  = 4'd2;
        #1;
        if (proc2mem_command !== BUS_STORE
            || proc2mem_data !== 64'hDEAD_BEEF_CAFE_F00D
            || mem2dcache_response !== 4'd2) begin
            $display("FAIL st_bus got cmd=%0d data=%0h resp=%0d want 2/deadbeefcafef00d/2",
                     proc2mem_command, proc2mem_data, mem2dcache_response);
            n_fail++;
        end
        n_tests++;
        step();
        idle();
        step();
        mem2proc_tag = 4'd2;
        #1;
        if (tag_error !== 1'b1 || mem2dcache_tag !== 4'd0
            || mem2icache_tag !== 4'd0) begin
            $display("FAIL st_tag got err=%0b d=%0d i=%0d want 1/0/0",
                     tag_error, mem2dcache_tag, mem2icache_tag);
            n_fail++;
        end
        n_tests++;
        step();
        idle();
        step();
    endtask

    task automatic test_reuse();
        idle();
        icache2mem_command = BUS_LOAD;
        icache2mem_addr    = 32'h700;
        mem2proc_response  = 4'd7;
        step();
        idle();
        dcache2mem_command = BUS_LOAD;
        dcache2mem_addr    = 32'h800;
        mem2proc_response  = 4'd7;
        mem2proc_tag       = 4'd7;
        #1;
        if (mem2icache_tag !== 4'd7 || mem2dcache_tag !== 4'd0
            || mem2dcache_response !== 4'd7) begin
            $display("FAIL ru_same got i=%0d d=%0d resp=%0d want 7/0/7",
                     mem2icache_tag, mem2dcache_tag, mem2dcache_response);
            n_fail++;
        end
        n_tests++;
        step();
        idle();
        step();
        mem2proc_tag = 4'd7;
        #1;
        if (mem2dcache_tag !== 4'd7 || mem2icache_tag !== 4'd0
            || tag_error !== 1'b0) begin
            $display("FAIL ru_next got d=%0d i=%0d err=%0b want 7/0/0",
                     mem2dcache_tag, mem2icache_tag, tag_error);
            n_fail++;
        end
        n_tests++;
        step();
        idle();
        step();
    endtask

    task automatic test_reset_midflight();
        idle();
        icache2mem_command = BUS_LOAD;
        mem2proc_response  = 4'd1;
        step();
        idle();
        dcache2mem_command = BUS_LOAD;
        mem2proc_response  = 4'd4;
        step();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        mem2proc_tag = 4'd4;
        #1;
        if (tag_error !== 1'b1 || mem2dcache_tag !== 4'd0
            || mem2icache_tag !== 4'd0) begin
            $display("FAIL rm_tag4 got err=%0b d=%0d i=%0d want 1/0/0",
                     tag_error, mem2dcache_tag, mem2icache_tag);
            n_fail++;
        end
        n_tests++;
        step();
        mem2proc_tag = 4'd1;
        #1;
        if (tag_error !== 1'b1 || mem2icache_tag !== 4'd0) begin
            $display("FAIL rm_tag1 got err=%0b i=%0d want 1/0",
                     tag_error, mem2icache_tag);
            n_fail++;
        end
        n_tests++;
        step();
        idle();
        step();
    endtask

    task automatic test_idle();
        idle();
        #1;
        if (proc2mem_command !== BUS_NONE || proc2mem_addr !== 32'h0
            || proc2mem_data !== 64'h0 || d_request !== 1'b0) begin
            $display("FAIL idle_bus got cmd=%0d addr=%0h data=%0h dreq=%0b want 0",
                     proc2mem_command, proc2mem_addr, proc2mem_data, d_request);
            n_fail++;
        end
        n_tests++;
        step();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_icache_only();
        test_contention();
        test_starvation();
        test_store();
        test_reuse();
        test_reset_midflight();
        test_idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single memory bus between the data cache and the instruction cache (the icache's demand fetches and prefetches arrive on one port). It grants the bus each cycle, tracks which requester owns each outstanding memory tag, and routes returning data and tags only to their owner. Its `d_request` output is what the icache uses to mask its response input. It sits between both caches and `mem`.

## Interface
- `STARVE_LIMIT`, default 4: number of consecutive cycles the dcache may win while the icache waits before the icache is forced through.
- `clock` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `dcache2mem_command` in 2: BUS_NONE/BUS_LOAD/BUS_STORE.
- `dcache2mem_addr` in XLEN: dcache address.
- `dcache2mem_data` in 64: store data.
- `icache2mem_command` in 2: BUS_NONE/BUS_LOAD.
- `icache2mem_addr` in XLEN: icache address.
- `mem2proc_response` in 4: tag accepted by memory; 0 means rejected.
- `mem2proc_data` in 64: returning data.
- `mem2proc_tag` in 4: returning tag; 0 means none.
- `proc2mem_command` out 2: bus command.
- `proc2mem_addr` out XLEN: bus address.
- `proc2mem_data` out 64: bus store data.
- `d_request` out 1: dcache owns the bus this cycle.
- `mem2dcache_response` out 4 and `mem2icache_response` out 4: accept tag, or 0 when the requester is not granted.
- `mem2dcache_tag` out 4 and `mem2icache_tag` out 4: returning tag if owned by this requester, else 0.
- `mem2dcache_data` out 64 and `mem2icache_data` out 64: `mem2proc_data`, passed unconditionally.
- `tag_error` out 1: one-cycle pulse when a nonzero tag returns with no recorded owner.

## Operation
- **Grant (combinational).**
  - The dcache wins whenever its command is not BUS_NONE, unless the starvation override is active.
  - The icache is granted otherwise.
  - `proc2mem_*` mirror the granted requester; all are 0/BUS_NONE when neither requests.
- **`d_request`** = dcache command ≠ BUS_NONE and override inactive.
- **Response steering.** `mem2proc_response` goes to the granted requester only; the other side sees 0.
- **Starvation counter** (width clog2(STARVE_LIMIT+1)):
  - Increments when the dcache is granted while the icache command ≠ BUS_NONE.
  - Clears when the icache is granted or the icache is idle.
  - Override is active when counter == STARVE_LIMIT: icache granted that cycle, counter clears.
- **Tag table.** Entries 1..15, each holding `valid` and `owner_is_d`.
  - On grant of a BUS_LOAD with response ≠ 0, the entry is set at the next edge.
  - Stores are never recorded.
- **Tag return.**
  - When `mem2proc_tag` ≠ 0 and its entry is valid: the tag goes to the owner's `*_tag` output, the other side sees 0, and the entry clears at the next edge.
  - When the entry is invalid: both sides see 0 and `tag_error` pulses.
- **Simultaneous return and reallocation of the same tag in one cycle:** clear first, then set; the entry ends valid with the new owner.

## Timing
- Grant, `d_request`, response steering and tag routing are all same-cycle combinational.
- The tag table and starvation counter update on posedge clock.
- The routing decision uses the table's registered state.
- **Reset values:**
  - All table entries invalid, counter 0.
  - While `reset` is high: `proc2mem_command` = BUS_NONE, `d_request` = 0, all response and tag outputs 0, `tag_error` 0.
- **Reset mid-operation:** outstanding ownership is discarded. Tags that return later raise `tag_error` and are routed nowhere.
- **Both requesters idle:** no table change and counter holds 0.

## Structure
- BUS_NONE/BUS_LOAD/BUS_STORE, XLEN and the STARVE_LIMIT default live in the shared sys_defs package.
- One sub-module, `mem_tag_table`: 15-entry owner table with allocate and clear ports and a combinational lookup.
- Grant, starvation counter and steering stay in `mem_arbiter`.

## Test plan
- **Icache only:** icache BUS_LOAD 0x100, mem response 3 → `mem2icache_response`=3, `d_request`=0; later tag 3 → `mem2icache_tag`=3, `mem2dcache_tag`=0.
- **Contention:** both request, response 5 → `d_request`=1, `mem2dcache_response`=5, `mem2icache_response`=0; tag 5 later routes to the dcache only.
- **Starvation:** both request continuously with STARVE_LIMIT=4 → the dcache wins cycles 0–3, the icache is granted in cycle 4 with `d_request`=0, and the counter returns to 0.
- **Dcache store:** dcache BUS_STORE, response 2 → no table entry; a spurious tag 2 → `tag_error`=1, both tag outputs 0.
- **Same-cycle return and reuse:** tag 7 returns for the icache while the dcache load is accepted with tag 7 → icache sees tag 7 this cycle, and the next return of 7 routes to the dcache.
- **Reset mid-flight:** reset with tags 1 and 4 outstanding, then tag 4 returns → `tag_error`=1, both tag outputs 0.
